// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the 5-stage core hazard controller.
//   - fwd_sel_t  : Execute-stage ALU operand source select
//   - hz_state_t : hazard controller sequencing state
//   - RES_MEM    : ResultSrc encoding that marks a load
//   - REG_ZERO   : architectural zero register, never forwarded
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // operand comes from the register file
        FWD_W  = 2'b01,   // operand forwarded from Writeback
        FWD_M  = 2'b10    // operand forwarded from Memory
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
//   Combinational operand forwarding select for one Execute-stage source.
//   Ports:
//     rs          in  5  source register of the Execute instruction
//     rd_m        in  5  destination register of the Memory instruction
//     rd_w        in  5  destination register of the Writeback instruction
//     reg_write_m in  1  Memory instruction writes the register file
//     reg_write_w in  1  Writeback instruction writes the register file
//     fwd_sel     out 2  operand source select
// ---------------------------------------------------------------------------
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   fwd_sel
);

    // Memory stage holds the younger result, so it is checked first.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Hazard, stall and forwarding controller for the 5-stage (F/D/E/M/W) core.
//   Forwards ALU operands into Execute, inserts a bubble on load-use,
//   flushes Decode/Execute on taken branches, freezes the pipe while data
//   memory is busy (bounded by MEM_TIMEOUT cycles), and counts stall and
//   branch-flush cycles.
//
//   Parameters:
//     MEM_TIMEOUT  maximum contiguous memory-stall cycles (1..31)
//     CNT_W        width of the saturating performance counters
//   Ports:
//     clk, reset                         clock, synchronous active-high reset
//     Rs1D, Rs2D                         Decode source registers
//     Rs1E, Rs2E, RdE                    Execute source/destination registers
//     RdM, RdW, RegWriteM, RegWriteW     Memory/Writeback writeback info
//     ResultSrcE                         Execute result source (load = RES_MEM)
//     PCSrcE                             branch/jump taken in Execute
//     MemAccessM, mem_ready              data memory access and completion
//     clear_stats                        clear both counters
//     StallF/D/E/M, FlushD/E/W           pipeline register enables
//     ForwardAE, ForwardBE               Execute operand selects
//     mem_error                          sticky memory-timeout flag
//     stall_count, flush_count           saturating performance counters
//
//   Outputs are Mealy: they depend on the current state and this cycle's
//   inputs. All stall/flush/forward outputs are held at zero during reset.
// ---------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             mem_ready,
    input  logic             clear_stats,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [4:0]       TIMEOUT_CNT = 5'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    hz_state_t        state_q, state_d;
    logic [4:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    fwd_sel_t fwd_a, fwd_b;

    logic lwstall, memwait;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic branch_flush;

    forward_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b)
    );

    always_comb begin
        lwstall = (ResultSrcE == RES_MEM) && (RdE != REG_ZERO) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
        memwait = MemAccessM && !mem_ready;

        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_error_d  = mem_error_q;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_w      = 1'b0;
        branch_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (memwait) begin
                    // Freeze F..M; Writeback gets a bubble so the stalled
                    // Memory instruction is not retired twice.
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    stall_m    = 1'b1;
                    flush_w    = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 5'd1;
                end else if (PCSrcE) begin
                    // The branch discards the Decode instruction, so any
                    // load-use hazard it carried no longer matters.
                    flush_d      = 1'b1;
                    flush_e      = 1'b1;
                    branch_flush = 1'b1;
                end else if (lwstall) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch and load-use are not evaluated here: the Execute
                // instruction is frozen and re-evaluates after release.
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 5'd0;
                end else if (wait_cnt_q < TIMEOUT_CNT) begin
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    stall_m    = 1'b1;
                    flush_w    = 1'b1;
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end else begin
                    // Timeout: release the pipe and record the error.
                    state_d     = RUN;
                    wait_cnt_d  = 5'd0;
                    mem_error_d = 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 5'd0;
            end
        endcase

        if (reset) begin
            stall_f      = 1'b0;
            stall_d      = 1'b0;
            stall_e      = 1'b0;
            stall_m      = 1'b0;
            flush_d      = 1'b0;
            flush_e      = 1'b0;
            flush_w      = 1'b0;
            branch_flush = 1'b0;
        end

        // clear_stats wins over an increment in the same cycle.
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clear_stats) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_f && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (branch_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 5'd0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallF      = stall_f;
    assign StallD      = stall_d;
    assign StallE      = stall_e;
    assign StallM      = stall_m;
    assign FlushD      = flush_d;
    assign FlushE      = flush_e;
    assign FlushW      = flush_w;
    assign ForwardAE   = reset ? FWD_RF : fwd_a;
    assign ForwardBE   = reset ? FWD_RF : fwd_b;
    assign mem_error   = mem_error_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//   Self-checking bench for hazard_controller (MEM_TIMEOUT = 4, CNT_W = 8).
//   A table of single-cycle vectors covers forwarding and RUN-state
//   stall/flush decisions; hand-written sequences cover the counters,
//   memory wait, timeout, saturation, clear and reset-during-wait.
//   Control outputs are compared packed as
//   {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] C_NONE = 7'b0000_000;
    localparam logic [6:0] C_LW   = 7'b1100_010;
    localparam logic [6:0] C_BR   = 7'b0000_110;
    localparam logic [6:0] C_MW   = 7'b1111_001;

    logic             clk;
    logic             reset;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             reg_write_m, reg_write_w;
    logic [1:0]       result_src_e;
    logic             pc_src_e, mem_access_m, mem_ready, clear_stats;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w;
    logic [1:0]       forward_ae, forward_be;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_controller #(
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1D        (rs1_d),
        .Rs2D        (rs2_d),
        .Rs1E        (rs1_e),
        .Rs2E        (rs2_e),
        .RdE         (rd_e),
        .RdM         (rd_m),
        .RdW         (rd_w),
        .RegWriteM   (reg_write_m),
        .RegWriteW   (reg_write_w),
        .ResultSrcE  (result_src_e),
        .PCSrcE      (pc_src_e),
        .MemAccessM  (mem_access_m),
        .mem_ready   (mem_ready),
        .clear_stats (clear_stats),
        .StallF      (stall_f),
        .StallD      (stall_d),
        .StallE      (stall_e),
        .StallM      (stall_m),
        .FlushD      (flush_d),
        .FlushE      (flush_e),
        .FlushW      (flush_w),
        .ForwardAE   (forward_ae),
        .ForwardBE   (forward_be),
        .mem_error   (mem_error),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [4:0] rs1d;
        logic [4:0] rs2d;
        logic [4:0] rs1e;
        logic [4:0] rs2e;
        logic [4:0] rde;
        logic [4:0] rdm;
        logic [4:0] rdw;
        logic       rwm;
        logic       rww;
        logic [1:0] res_src;
        logic       pcsrc;
        logic       mem_acc;
        logic       mem_rdy;
        logic [6:0] exp_ctrl;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    // ---------------- driver tasks ----------------
    task automatic idle();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        reg_write_m = 1'b0; reg_write_w = 1'b0;
        result_src_e = 2'b00; pc_src_e = 1'b0;
        mem_access_m = 1'b0; mem_ready = 1'b1; clear_stats = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rs1_d = v.rs1d; rs2_d = v.rs2d; rs1_e = v.rs1e; rs2_e = v.rs2e;
        rd_e = v.rde; rd_m = v.rdm; rd_w = v.rdw;
        reg_write_m = v.rwm; reg_write_w = v.rww;
        result_src_e = v.res_src; pc_src_e = v.pcsrc;
        mem_access_m = v.mem_acc; mem_ready = v.mem_rdy;
    endtask

    task automatic load_use();
        result_src_e = 2'b01; rd_e = 5'd3; rs2_d = 5'd3;
    endtask

    // One clock edge, then settle away from it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        idle();
        clear_stats = 1'b1;
        #1;
        cycle();
        clear_stats = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
    endfunction

    // ---------------- test ----------------
    initial begin
        // rs1d rs2d rs1e rs2e rde rdm rdw rwm rww res pc acc rdy ctrl fa fb
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b10, 2'b00};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b01, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[4]  = '{5'd0, 5'd0, 5'd9, 5'd7, 5'd0, 5'd7, 5'd9, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b01, 2'b10};
        vecs[5]  = '{5'd0, 5'd0, 5'd9, 5'd4, 5'd0, 5'd3, 5'd9, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[6]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, C_LW,   2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[8]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[9]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, C_LW,   2'b00, 2'b00};
        vecs[10] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[11] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, C_BR,   2'b00, 2'b00};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, C_BR,   2'b00, 2'b00};
        vecs[14] = '{5'd2, 5'd5, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[15] = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd0, 5'd8, 5'd8, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, C_NONE, 2'b10, 2'b10};
        vecs[16] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, C_LW,   2'b00, 2'b00};

        // ---- reset with hazardous inputs: everything forced low ----
        idle();
        reset = 1'b1;
        mem_access_m = 1'b1; mem_ready = 1'b0; pc_src_e = 1'b1;
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd5;
        #1;
        check("reset_ctrl", 32'(ctrl_now()), 32'(C_NONE));
        check("reset_fwd", 32'({forward_ae, forward_be}), 32'd0);
        cycle();
        check("reset_mem_error", 32'(mem_error), 32'd0);
        check("reset_stall_count", 32'(stall_count), 32'd0);
        check("reset_flush_count", 32'(flush_count), 32'd0);
        reset = 1'b0;
        idle();
        #1;
        cycle();

        // ---- table vectors ----
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d_fwd", i), 32'({forward_ae, forward_be}),
                  32'({vecs[i].exp_fa, vecs[i].exp_fb}));
            cycle();
        end

        // ---- load-use: exactly one counted stall ----
        clear_counters();
        check("clear_stall_count", 32'(stall_count), 32'd0);
        check("clear_flush_count", 32'(flush_count), 32'd0);
        load_use();
        #1;
        check("lu_ctrl", 32'(ctrl_now()), 32'(C_LW));
        cycle();
        idle();
        #1;
        check("lu_bubble_gone", 32'(ctrl_now()), 32'(C_NONE));
        check("lu_stall_count", 32'(stall_count), 32'd1);
        cycle();

        // ---- branch beats load-use ----
        load_use();
        pc_src_e = 1'b1;
        #1;
        check("br_lu_ctrl", 32'(ctrl_now()), 32'(C_BR));
        cycle();
        check("br_flush_count", 32'(flush_count), 32'd1);
        check("br_stall_count", 32'(stall_count), 32'd1);

        // ---- memory wait, 3 cycles then ready; branch ignored ----
        clear_counters();
        mem_access_m = 1'b1;
        mem_ready    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pc_src_e = (k == 1);
            reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
            #1;
            check($sformatf("mw_ctrl%0d", k), 32'(ctrl_now()), 32'(C_MW));
            check($sformatf("mw_fwd%0d", k), 32'(forward_ae), 32'd2);
            cycle();
        end
        pc_src_e  = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("mw_release", 32'(ctrl_now()), 32'(C_NONE));
        cycle();
        check("mw_stall_count", 32'(stall_count), 32'd3);
        check("mw_flush_count", 32'(flush_count), 32'd0);
        idle();
        pc_src_e = 1'b1;
        #1;
        check("mw_back_in_run", 32'(ctrl_now()), 32'(C_BR));
        cycle();

        // ---- timeout: 4 stall cycles, forced release on the 5th ----
        clear_counters();
        mem_access_m = 1'b1;
        mem_ready    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("to_ctrl%0d", k), 32'(ctrl_now()), 32'(C_MW));
            cycle();
            check($sformatf("to_err%0d", k), 32'(mem_error), 32'd0);
        end
        #1;
        check("to_release", 32'(ctrl_now()), 32'(C_NONE));
        cycle();
        check("to_err_set", 32'(mem_error), 32'd1);
        check("to_stall_count", 32'(stall_count), 32'd4);
        idle();
        #1;
        repeat (3) cycle();
        check("to_err_sticky", 32'(mem_error), 32'd1);

        // ---- saturation and clear overriding an increment ----
        clear_counters();
        load_use();
        repeat (300) cycle();
        check("sat_stall_count", 32'(stall_count), 32'hFF);
        clear_stats = 1'b1;
        #1;
        cycle();
        check("sat_clear", 32'(stall_count), 32'd0);
        clear_stats = 1'b0;
        cycle();
        check("sat_restart", 32'(stall_count), 32'd1);

        // ---- reset during MEM_WAIT ----
        idle();
        mem_access_m = 1'b1;
        mem_ready    = 1'b0;
        #1;
        cycle();
        cycle();
        reset = 1'b1;
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
        #1;
        check("rst_wait_ctrl", 32'(ctrl_now()), 32'(C_NONE));
        check("rst_wait_fwd", 32'(forward_ae), 32'd0);
        cycle();
        check("rst_wait_err", 32'(mem_error), 32'd0);
        check("rst_wait_stall_count", 32'(stall_count), 32'd0);
        reset = 1'b0;
        idle();
        pc_src_e = 1'b1;
        #1;
        check("rst_wait_in_run", 32'(ctrl_now()), 32'(C_BR));
        cycle();
        idle();
        #1;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
